// File: rtl/tc_mod_counter.sv
// Modulo-N up/down counter with a compile-time step, load range check, wrap pulse and terminal count.
// Define TC_MOD_COUNTER_SAT_EN to clip at the period ends instead of wrapping.
module tc_mod_counter #(
  parameter int unsigned UUID      = 0,
  parameter              NAME      = "",
  parameter int          BIT_WIDTH = 8,
  parameter int          STEP      = 1,
  parameter int          MODULUS   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 save_i,
  input  logic [BIT_WIDTH-1:0] in_i,
  input  logic                 en_i,
  input  logic                 dir_i,
  output logic [BIT_WIDTH-1:0] out_o,
  output logic                 wrap_o,
  output logic                 tc_o,
  output logic                 load_err_o
);

  localparam longint unsigned FULL_L    = 64'd1 << BIT_WIDTH;
  localparam longint unsigned EFF_MOD_L = (MODULUS == 0) ? FULL_L : 64'(MODULUS);
  localparam bit              POW2      = (EFF_MOD_L == FULL_L);
  localparam logic [BIT_WIDTH:0]   EFF_MOD = (BIT_WIDTH+1)'(EFF_MOD_L);
  localparam logic [BIT_WIDTH:0]   STEP_W  = (BIT_WIDTH+1)'(STEP);
  localparam logic [BIT_WIDTH-1:0] MAX_V   = BIT_WIDTH'(EFF_MOD_L - 64'd1);

  if (BIT_WIDTH < 1 || BIT_WIDTH > 32) begin : g_bad_width
    $error("tc_mod_counter: BIT_WIDTH must be 1..32");
  end
  if (MODULUS != 0 && (MODULUS < 2 || 64'(MODULUS) > FULL_L)) begin : g_bad_mod
    $error("tc_mod_counter: MODULUS must be 0 or 2..2^BIT_WIDTH");
  end
  if (STEP < 1 || 64'(STEP) > EFF_MOD_L - 64'd1) begin : g_bad_step
    $error("tc_mod_counter: STEP must be 1..EFF_MOD-1");
  end

  logic [BIT_WIDTH-1:0] out_q, out_d;
  logic                 wrap_q, wrap_d;
  logic                 lerr_q, lerr_d;

  logic [BIT_WIDTH:0] ext_w, up_sum_w, dn_sub_w;
  logic               up_ovf_w, dn_brw_w;

  // Arithmetic at BIT_WIDTH+1 bits; for a full power-of-two period the carry/borrow bit is the wrap.
  assign ext_w    = {1'b0, out_q};
  assign up_sum_w = ext_w + STEP_W;
  assign dn_sub_w = ext_w - STEP_W;
  assign up_ovf_w = POW2 ? up_sum_w[BIT_WIDTH] : (up_sum_w >= EFF_MOD);
  assign dn_brw_w = POW2 ? dn_sub_w[BIT_WIDTH] : (ext_w < STEP_W);

`ifndef TC_MOD_COUNTER_SAT_EN
  logic [BIT_WIDTH:0] up_wrap_w, dn_wrap_w;
  assign up_wrap_w = up_sum_w - EFF_MOD;
  assign dn_wrap_w = ext_w + EFF_MOD - STEP_W;
`endif

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (save_i) begin
      if ({1'b0, in_i} < EFF_MOD) begin
        out_d = in_i;
      end else begin
        out_d  = '0;
        lerr_d = 1'b1;
      end
    end else if (en_i) begin
      if (!dir_i) begin
        if (up_ovf_w) begin
          wrap_d = 1'b1;
`ifdef TC_MOD_COUNTER_SAT_EN
          out_d  = MAX_V;
`else
          out_d  = up_wrap_w[BIT_WIDTH-1:0];
`endif
        end else begin
          out_d = up_sum_w[BIT_WIDTH-1:0];
        end
      end else begin
        if (dn_brw_w) begin
          wrap_d = 1'b1;
`ifdef TC_MOD_COUNTER_SAT_EN
          out_d  = '0;
`else
          out_d  = dn_wrap_w[BIT_WIDTH-1:0];
`endif
        end else begin
          out_d = dn_sub_w[BIT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign out_o      = out_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = lerr_q;
  assign tc_o       = dir_i ? (out_q == '0) : (out_q == MAX_V);

endmodule
